mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store engine that consumes the EX/MEM pipeline register outputs and executes the data-memory access for the instruction held there. Drives a variable-latency data-memory request/acknowledge port, generates byte enables and replicated store data, sign/zero-extends load data, and stalls the pipeline until the access completes. Sits between the EX/MEM register and the MEM/WB register; non-memory instructions pass through with zero added latency.

## Interface
- NBITS, 32, datapath and address width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; asynchronous and active-low
- MEM_result  in  NBITS  effective address from the ALU
- MEM_Rt  in  NBITS  store data
- MEM_storesize  in  2  00 byte, 01 half, 10/11 word
- MEM_loadcontrol  in  3  000 LB, 001 LH, 100 LBU, 101 LHU, any other value LW
- MEM_memread, MEM_memwrite  in  1  access request; memwrite takes priority if both are set
- o_dmem_req  out  1  memory request, held until ack
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  NBITS  word address {MEM_result[NBITS-1:2],2'b00}
- o_dmem_be  out  4  byte enables, little-endian
- o_dmem_wdata  out  NBITS  replicated store data
- i_dmem_ack  in  1  access complete; rdata valid in the same cycle
- i_dmem_rdata  in  NBITS  read word
- o_load_data  out  NBITS  extended load result toward MEM/WB
- o_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- o_misalign  out  1  misaligned access detected; no memory access issued

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, no access: o_stall=0 and o_dmem_req=0.
- IDLE, aligned access: o_stall=1 (combinational). On the next edge, register req=1, we, addr, be, wdata, and byte offset MEM_result[1:0]; move to BUSY.
- IDLE, misaligned access: o_misalign=1 (combinational), o_stall=0, no request issued, state stays IDLE. A half access is misaligned when addr[0]=1. A word access is misaligned when addr[1:0]!=0.
- BUSY: o_stall=1 and req held with stable addr, be and wdata. On i_dmem_ack: drop req; for a load, capture the extended rdata into the o_load_data register; move to DONE.
- DONE: o_stall=0. o_load_data holds the result for the MEM/WB capture edge. Next edge goes to IDLE.
- The EX/MEM register advances on every edge where o_stall=0. DONE therefore always sees a new instruction in the following IDLE cycle.
- Store byte enables and data:
  - Byte: be=1<<off, wdata={4{Rt[7:0]}}.
  - Half: off 0 gives be=0011, off 2 gives be=1100, wdata={2{Rt[15:0]}}.
  - Word: be=1111, wdata=Rt.
- Loads: be=1111. Select byte or half lane by the captured offset, then sign- or zero-extend per loadcontrol.
- i_dmem_ack outside BUSY is ignored.

## Timing
- Reset (i_rst_n low, asynchronous) forces:
  - state=IDLE, o_dmem_req=0, o_dmem_we=0
  - o_dmem_addr, o_dmem_be, o_dmem_wdata and o_load_data all 0
  - o_stall=0 and o_misalign=0 while reset is held
- Reset mid-BUSY aborts the access immediately; no ack is awaited afterwards.
- A memory instruction occupies MEM for 2+W cycles, where W is the number of BUSY cycles until ack (W≥1). With zero-wait memory (ack in the first BUSY cycle), a load or store takes 3 cycles.
- Non-memory and misaligned instructions take 1 cycle in MEM.
- o_dmem_* outputs are registered; o_stall and o_misalign are combinational from state and inputs.

## Structure
- Package mem_pkg holds:
  - storesize encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - loadcontrol encodings LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU
  - the FSM state type
- Sub-module load_extender (combinational) takes rdata, offset and loadcontrol and returns the extended word. It is reused by any future cache path.

## Test plan
- SB at addr 0x0000_0013, Rt=0x1234_56AB, ack after 2 BUSY cycles -> addr 0x10, be=1000, wdata=0xABAB_ABAB, we=1; o_stall high for 3 cycles, then low in DONE.
- LB at addr 0x21, rdata=0x0000_8000 -> o_load_data=0xFFFF_FF80 in DONE. LBU at the same address -> 0x0000_0080.
- LH at addr 0x02, rdata=0xBEEF_0000 -> be=1111, o_load_data=0xFFFF_BEEF. LHU -> 0x0000_BEEF.
- LW at addr 0x06 -> o_misalign=1, o_stall=0, o_dmem_req never asserted. SH at addr 0x05 -> same response.
- ADD (memread=memwrite=0) followed by back-to-back SW/LW with zero-wait ack -> no stall on the ADD; each access shows IDLE(stall)→BUSY→DONE; no request gap is lost.
- Assert i_rst_n low in the second BUSY cycle of a LW -> req drops asynchronously and all outputs return to 0. A stray ack after reset release is ignored and state stays IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and FSM state type for the MEM-stage load/store engine.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mau_state_e;

  typedef enum logic [1:0] {
    ACC_BYTE,
    ACC_HALF,
    ACC_WORD
  } acc_size_e;

  // Stores take their width from storesize; loads take it from loadcontrol,
  // where every unlisted loadcontrol value behaves as a full word.
  function automatic acc_size_e access_size(input logic       is_store,
                                            input logic [1:0] storesize,
                                            input logic [2:0] loadcontrol);
    acc_size_e sz;
    sz = ACC_WORD;
    if (is_store) begin
      case (storesize)
        SZ_BYTE: sz = ACC_BYTE;
        SZ_HALF: sz = ACC_HALF;
        default: sz = ACC_WORD;
      endcase
    end else begin
      case (loadcontrol)
        LD_LB, LD_LBU: sz = ACC_BYTE;
        LD_LH, LD_LHU: sz = ACC_HALF;
        default:       sz = ACC_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_extender
  import mem_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0] rdata_i,
  input  logic [1:0]       off_i,
  input  logic [2:0]       ldctl_i,
  output logic [NBITS-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[16 +: 16] : rdata_i[0 +: 16];
    case (ldctl_i)
      LD_LB:   data_o = {{(NBITS-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  data_o = {{(NBITS-8){1'b0}}, byte_sel};
      LD_LH:   data_o = {{(NBITS-16){half_sel[15]}}, half_sel};
      LD_LHU:  data_o = {{(NBITS-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one data-memory access per memory instruction
// over a req/ack port and stalls the pipeline until the access completes.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NBITS-1:0] MEM_result,
  input  logic [NBITS-1:0] MEM_Rt,
  input  logic [1:0]       MEM_storesize,
  input  logic [2:0]       MEM_loadcontrol,
  input  logic             MEM_memread,
  input  logic             MEM_memwrite,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [NBITS-1:0] o_dmem_addr,
  output logic [3:0]       o_dmem_be,
  output logic [NBITS-1:0] o_dmem_wdata,
  input  logic             i_dmem_ack,
  input  logic [NBITS-1:0] i_dmem_rdata,
  output logic [NBITS-1:0] o_load_data,
  output logic             o_stall,
  output logic             o_misalign
);

  mau_state_e       state_q;
  logic             req_q;
  logic             we_q;
  logic [NBITS-1:0] addr_q;
  logic [3:0]       be_q;
  logic [NBITS-1:0] wdata_q;
  logic [1:0]       off_q;
  logic [2:0]       ldctl_q;
  logic [NBITS-1:0] load_q;

  logic             access;
  logic             is_store;
  logic [1:0]       off;
  acc_size_e        size;
  logic             misalign;
  logic             idle_access;
  logic [3:0]       be_d;
  logic [NBITS-1:0] wdata_d;
  logic [NBITS-1:0] ext_data;

  assign access   = MEM_memread | MEM_memwrite;
  assign is_store = MEM_memwrite;
  assign off      = MEM_result[1:0];

  always_comb begin
    size     = access_size(is_store, MEM_storesize, MEM_loadcontrol);
    misalign = 1'b0;
    be_d     = 4'b1111;
    wdata_d  = MEM_Rt;
    case (size)
      ACC_HALF: misalign = off[0];
      ACC_WORD: misalign = |off;
      default:  misalign = 1'b0;
    endcase
    if (is_store) begin
      case (size)
        ACC_BYTE: begin
          be_d    = 4'b0001 << off;
          wdata_d = {(NBITS/8){MEM_Rt[7:0]}};
        end
        ACC_HALF: begin
          be_d    = off[1] ? 4'b1100 : 4'b0011;
          wdata_d = {(NBITS/16){MEM_Rt[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = MEM_Rt;
        end
      endcase
    end
  end

  // Gating with i_rst_n keeps stall/misalign low while reset is held, even
  // though the EX/MEM register may still be presenting a memory instruction.
  assign idle_access = i_rst_n && (state_q == ST_IDLE) && access;
  assign o_misalign  = idle_access && misalign;
  assign o_stall     = (idle_access && !misalign) || (state_q == ST_BUSY);

  load_extender #(
    .NBITS(NBITS)
  ) u_load_extender (
    .rdata_i (i_dmem_rdata),
    .off_i   (off_q),
    .ldctl_i (ldctl_q),
    .data_o  (ext_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      ldctl_q <= '0;
      load_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access && !misalign) begin
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= {MEM_result[NBITS-1:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off;
            ldctl_q <= MEM_loadcontrol;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (i_dmem_ack) begin
            req_q   <= 1'b0;
            if (!we_q) begin
              load_q <= ext_data;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_dmem_req   = req_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;
  assign o_load_data  = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver models the EX/MEM register, a
// memory model answers requests, and a monitor checks requests and load results.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_result;
  logic [31:0] mem_rt;
  logic [1:0]  mem_storesize;
  logic [2:0]  mem_loadcontrol;
  logic        mem_memread;
  logic        mem_memwrite;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        stall;
  logic        misalign;

  mem_access_unit #(.NBITS(32)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .MEM_result      (mem_result),
    .MEM_Rt          (mem_rt),
    .MEM_storesize   (mem_storesize),
    .MEM_loadcontrol (mem_loadcontrol),
    .MEM_memread     (mem_memread),
    .MEM_memwrite    (mem_memwrite),
    .o_dmem_req      (dmem_req),
    .o_dmem_we       (dmem_we),
    .o_dmem_addr     (dmem_addr),
    .o_dmem_be       (dmem_be),
    .o_dmem_wdata    (dmem_wdata),
    .i_dmem_ack      (dmem_ack),
    .i_dmem_rdata    (dmem_rdata),
    .o_load_data     (load_data),
    .o_stall         (stall),
    .o_misalign      (misalign)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cur_wait = 1;
  logic [31:0] cur_rdata = '0;
  bit          stray = 0;
  bit          pend = 0;
  bit          pend_load = 0;
  logic [31:0] pend_val = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model, expressed as byte arithmetic on the access width.
  function automatic int nb_of(input bit mw, input logic [1:0] ss, input logic [2:0] lc);
    if (mw) return (ss == 2'd0) ? 1 : (ss == 2'd1) ? 2 : 4;
    if (lc == 3'd0 || lc == 3'd4) return 1;
    if (lc == 3'd1 || lc == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] lc, input int off,
                                             input logic [31:0] rd, input int nb);
    logic [31:0] v;
    v = rd >> (8 * off);
    if (nb == 1) begin
      v = v & 32'h0000_00FF;
      if (lc == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (nb == 2) begin
      v = v & 32'h0000_FFFF;
      if (lc == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Memory model: ack after cur_wait cycles of a held request.
  initial begin
    int cnt;
    cnt = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (stray) begin
        dmem_ack = 1'b1;
        dmem_rdata = $urandom;
      end else if (dmem_req) begin
        cnt++;
        dmem_ack = (cnt == cur_wait);
        dmem_rdata = dmem_ack ? cur_rdata : $urandom;
      end else begin
        cnt = 0;
        dmem_ack = 1'b0;
      end
    end
  end

  // Monitor: checks each completed request, then the DONE cycle that follows.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && dmem_req && dmem_ack) begin
        if (sb_q.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("req_we", {31'd0, dmem_we}, {31'd0, e.we});
          check("req_addr", dmem_addr, e.addr);
          check("req_be", {28'd0, dmem_be}, {28'd0, e.be});
          if (e.we) check("req_wdata", dmem_wdata, e.wdata);
          check("busy_stall", {31'd0, stall}, 32'd1);
          pend = 1;
          pend_load = !e.we;
          pend_val = e.ldata;
        end
      end else if (pend) begin
        pend = 0;
        check("done_stall", {31'd0, stall}, 32'd0);
        check("done_req", {31'd0, dmem_req}, 32'd0);
        if (pend_load) check("load_data", load_data, pend_val);
      end
    end
  end

  // Presents one instruction in EX/MEM until it retires; call at posedge+2.
  task automatic issue(input bit mr, input bit mw, input logic [1:0] ss, input logic [2:0] lc,
                       input logic [31:0] a, input logic [31:0] rt, input logic [31:0] rd,
                       input int w);
    int   nb, off, cyc, expcyc;
    bit   acc, mis, done;
    exp_t e;
    acc = mr || mw;
    nb  = nb_of(mw, ss, lc);
    off = int'(a[1:0]);
    mis = acc && ((off % nb) != 0);
    cur_wait  = w;
    cur_rdata = rd;
    mem_memread = mr;
    mem_memwrite = mw;
    mem_storesize = ss;
    mem_loadcontrol = lc;
    mem_result = a;
    mem_rt = rt;
    if (acc && !mis) begin
      e.we    = mw;
      e.addr  = a & 32'hFFFF_FFFC;
      e.be    = mw ? 4'(((1 << nb) - 1) << off) : 4'hF;
      e.wdata = (nb == 1) ? rt[7:0] * 32'h0101_0101 :
                (nb == 2) ? rt[15:0] * 32'h0001_0001 : rt;
      e.ldata = model_load(lc, off, rd, nb);
      sb_q.push_back(e);
    end
    expcyc = (acc && !mis) ? 2 + w : 1;
    cyc = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      #2;
      cyc++;
      if (cyc == 1) check("misalign", {31'd0, misalign}, {31'd0, mis});
      if (!stall) done = 1;
      else if (cyc > 40) begin
        check("retire_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    check("mem_cycles", cyc, expcyc);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    mem_memread = 0;
    mem_memwrite = 0;
    mem_storesize = 0;
    mem_loadcontrol = 0;
    mem_result = 0;
    mem_rt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] lcs[8];
    lcs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    rst_n = 1'b0;
    idle_inputs();
    mem_memread = 1;
    mem_loadcontrol = 3'd2;
    mem_result = 32'h100;
    #12;
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_load", load_data, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // SB at 0x13, 2 BUSY cycles
    issue(0, 1, 2'b00, 3'd0, 32'h0000_0013, 32'h1234_56AB, 32'h0, 2);
    // LB / LBU at 0x21
    issue(1, 0, 2'b00, 3'd0, 32'h0000_0021, 32'h0, 32'h0000_8000, 1);
    issue(1, 0, 2'b00, 3'd4, 32'h0000_0021, 32'h0, 32'h0000_8000, 1);
    // LH / LHU at 0x02
    issue(1, 0, 2'b00, 3'd1, 32'h0000_0002, 32'h0, 32'hBEEF_0000, 2);
    issue(1, 0, 2'b00, 3'd5, 32'h0000_0002, 32'h0, 32'hBEEF_0000, 1);
    // misaligned LW and SH
    issue(1, 0, 2'b00, 3'd2, 32'h0000_0006, 32'h0, 32'h0, 1);
    issue(0, 1, 2'b01, 3'd0, 32'h0000_0005, 32'hCAFE_F00D, 32'h0, 1);
    // ADD then back-to-back SW / LW with zero-wait memory
    issue(0, 0, 2'b00, 3'd0, 32'h0000_1234, 32'h5, 32'h0, 1);
    issue(0, 1, 2'b10, 3'd0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1);
    issue(1, 0, 2'b00, 3'd2, 32'h0000_0044, 32'h0, 32'h1357_9BDF, 1);
    // both memread and memwrite: write wins
    issue(1, 1, 2'b11, 3'd0, 32'h0000_0048, 32'h0A0B_0C0D, 32'h0, 1);

    // Reset in the second BUSY cycle of a LW
    cur_wait = 5;
    cur_rdata = 32'hFFFF_FFFF;
    mem_memread = 1;
    mem_memwrite = 0;
    mem_loadcontrol = 3'd2;
    mem_result = 32'h0000_0080;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    check("abort_req_before", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_req", {31'd0, dmem_req}, 32'd0);
    check("abort_addr", dmem_addr, 32'd0);
    check("abort_be", {28'd0, dmem_be}, 32'd0);
    check("abort_load", load_data, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    pend = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    stray = 1;
    @(negedge clk);
    #2;
    check("stray_ack_seen", {31'd0, dmem_ack}, 32'd1);
    @(posedge clk);
    #2;
    stray = 0;
    @(negedge clk);
    #2;
    check("stray_req", {31'd0, dmem_req}, 32'd0);
    check("stray_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #2;
    issue(1, 0, 2'b00, 3'd0, 32'h0000_0093, 32'h0, 32'h7F00_0000, 2);

    // Randomized instruction mix
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      if (kind == 0)
        issue(0, 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a, $urandom, $urandom, 1);
      else if (kind < 6)
        issue(1, 0, 2'b00, lcs[$urandom_range(0, 7)], a, $urandom, $urandom, $urandom_range(1, 3));
      else
        issue(0, 1, 2'($urandom_range(0, 3)), 3'd0, a, $urandom, $urandom, $urandom_range(1, 3));
    end

    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
